// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the 16-bit accumulator CPU: fetch, decode,
// execute/memory/writeback with a req/ack memory handshake, timeout and retire counter.
module cpu_sequencer #(
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 mem_ack,
  input  logic [15:0]          mem_rdata,
  input  logic                 acc_zero,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 mem_addr_sel,
  output logic [15:0]          instr_reg,
  output logic [13:0]          imm_out,
  output logic                 pc_we,
  output logic                 pc_sel,
  output logic                 acc_we,
  output logic                 acc_sel,
  output logic                 busy,
  output logic                 error,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  localparam logic [1:0] OP_ADDI  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_BRZ   = 2'b11;

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  state_t        state_q;
  logic [TW-1:0] to_cnt;
  logic [1:0]    opcode;
  logic          waiting;
  logic          timed_out;

  assign opcode  = instr_reg[15:14];
  assign imm_out = instr_reg[13:0];
  assign state   = state_q;
  assign busy    = (state_q != S_IDLE);

  // Final unanswered request cycle; an ack in this same cycle still completes normally.
  assign waiting   = (state_q == S_FETCH) || (state_q == S_MEM);
  assign timed_out = waiting && !mem_ack && (to_cnt == TW'(ACK_TIMEOUT - 1));

  always_comb begin
    mem_req      = waiting;
    mem_addr_sel = (state_q == S_MEM);
    mem_we       = (state_q == S_MEM) && (opcode == OP_STORE);
    pc_we        = ((state_q == S_FETCH) && mem_ack) || ((state_q == S_EXEC) && acc_zero);
    pc_sel       = (state_q == S_EXEC);
    acc_we       = (state_q == S_WB);
    acc_sel      = (state_q == S_WB) && (opcode == OP_LOAD);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      instr_reg   <= '0;
      error       <= 1'b0;
      instr_count <= '0;
      to_cnt      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_FETCH;
            error   <= 1'b0;
            to_cnt  <= '0;
          end
        end
        S_FETCH: begin
          if (mem_ack) begin
            instr_reg <= mem_rdata;
            to_cnt    <= '0;
            state_q   <= S_DECODE;
          end else if (timed_out) begin
            error   <= 1'b1;
            to_cnt  <= '0;
            state_q <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_DECODE: begin
          case (opcode)
            OP_ADDI:  state_q <= S_WB;
            OP_LOAD:  state_q <= S_MEM;
            OP_STORE: state_q <= S_MEM;
            OP_BRZ:   state_q <= S_EXEC;
            default:  state_q <= S_IDLE;
          endcase
        end
        S_MEM: begin
          if (mem_ack) begin
            to_cnt <= '0;
            if (opcode == OP_STORE) begin
              instr_count <= instr_count + 1'b1;
              state_q     <= stop ? S_IDLE : S_FETCH;
            end else begin
              state_q <= S_WB;
            end
          end else if (timed_out) begin
            error   <= 1'b1;
            to_cnt  <= '0;
            state_q <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_EXEC, S_WB: begin
          instr_count <= instr_count + 1'b1;
          state_q     <= stop ? S_IDLE : S_FETCH;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
